// File: rtl/muldiv_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_unit_if
// Description : Request/response bundle between issue logic and muldiv_unit.
// Revision    : 1.0 - initial release
// ============================================================================
interface muldiv_unit_if;
    logic        start;
    logic [2:0]  funct3;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [4:0]  rd_in;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic [4:0]  rd_out;
    logic        reg_write;

    modport master (
        output start, funct3, rs1_data, rs2_data, rd_in,
        input  busy, done, result, rd_out, reg_write
    );

    modport slave (
        input  start, funct3, rs1_data, rs2_data, rd_in,
        output busy, done, result, rd_out, reg_write
    );
endinterface
`default_nettype wire

// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_unit
// Description : Iterative RV32M multiply/divide unit, one radix-2 step/cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module muldiv_unit (
    input  wire logic     clk,
    input  wire logic     reset,
    muldiv_unit_if.slave  bus
);
    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_CALC = 2'd1;
    localparam logic [1:0] c_FIX  = 2'd2;
    localparam logic [1:0] c_DONE = 2'd3;

    logic [1:0]  r_state;
    logic [1:0]  w_state_nxt;
    logic [5:0]  r_cnt;
    logic [2:0]  r_op;
    logic [4:0]  r_rd;
    logic        r_neg_q;
    logic        r_neg_r;
    logic [63:0] r_acc;
    logic [31:0] r_b;
    logic [31:0] r_result;
    logic [4:0]  r_rd_out;

    logic        w_sgn_a, w_sgn_b, w_sa, w_sb;
    logic [31:0] w_mag_a, w_mag_b;
    logic        w_div0, w_ovf, w_fast;
    logic [31:0] w_fast_res;
    logic [32:0] w_mul_sum;
    logic [63:0] w_mul_nxt;
    logic [32:0] w_div_sh, w_div_diff;
    logic        w_div_ok;
    logic [63:0] w_div_nxt;
    logic [63:0] w_prod;
    logic [31:0] w_quo, w_rem;
    logic [31:0] w_fix_res;
    logic        w_busy, w_done, w_reg_write;

    assign w_sgn_a = (bus.funct3 == 3'b001) || (bus.funct3 == 3'b010) ||
                     (bus.funct3 == 3'b100) || (bus.funct3 == 3'b110);
    assign w_sgn_b = (bus.funct3 == 3'b001) || (bus.funct3 == 3'b100) ||
                     (bus.funct3 == 3'b110);
    assign w_sa    = w_sgn_a & bus.rs1_data[31];
    assign w_sb    = w_sgn_b & bus.rs2_data[31];
    assign w_mag_a = w_sa ? (32'd0 - bus.rs1_data) : bus.rs1_data;
    assign w_mag_b = w_sb ? (32'd0 - bus.rs2_data) : bus.rs2_data;

    assign w_div0  = bus.funct3[2] && (bus.rs2_data == 32'd0);
    assign w_ovf   = bus.funct3[2] && !bus.funct3[0] &&
                     (bus.rs1_data == 32'h8000_0000) && (bus.rs2_data == 32'hFFFF_FFFF);
    assign w_fast  = w_div0 || w_ovf;
    assign w_fast_res = w_div0 ? (bus.funct3[1] ? bus.rs1_data : 32'hFFFF_FFFF)
                               : (bus.funct3[1] ? 32'd0 : 32'h8000_0000);

    // Multiply: product grows into the high half while the multiplier shifts out the low half
    assign w_mul_sum = {1'b0, r_acc[63:32]} + (r_acc[0] ? {1'b0, r_b} : 33'd0);
    assign w_mul_nxt = {w_mul_sum, r_acc[31:1]};

    // Divide: high half is the partial remainder, low half shifts dividend out / quotient in
    assign w_div_sh   = {r_acc[63:32], r_acc[31]};
    assign w_div_diff = w_div_sh - {1'b0, r_b};
    assign w_div_ok   = !w_div_diff[32];
    assign w_div_nxt  = {(w_div_ok ? w_div_diff[31:0] : w_div_sh[31:0]), r_acc[30:0], w_div_ok};

    assign w_prod = r_neg_q ? (64'd0 - r_acc) : r_acc;
    assign w_quo  = r_neg_q ? (32'd0 - r_acc[31:0]) : r_acc[31:0];
    assign w_rem  = r_neg_r ? (32'd0 - r_acc[63:32]) : r_acc[63:32];

    always_comb begin
        w_fix_res = w_rem;
        case (r_op)
            3'b000:                 w_fix_res = w_prod[31:0];
            3'b001, 3'b010, 3'b011: w_fix_res = w_prod[63:32];
            3'b100, 3'b101:         w_fix_res = w_quo;
            default:                w_fix_res = w_rem;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) r_state <= c_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE:  if (bus.start) w_state_nxt = w_fast ? c_DONE : c_CALC;
            c_CALC:  if (r_cnt == 6'd31) w_state_nxt = c_FIX;
            c_FIX:   w_state_nxt = c_DONE;
            default: w_state_nxt = c_IDLE;
        endcase
    end

    always_comb begin
        w_busy      = (r_state != c_IDLE);
        w_done      = (r_state == c_DONE);
        w_reg_write = w_done && (r_rd_out != 5'd0);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_cnt    <= 6'd0;
            r_op     <= 3'd0;
            r_rd     <= 5'd0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_acc    <= 64'd0;
            r_b      <= 32'd0;
            r_result <= 32'd0;
            r_rd_out <= 5'd0;
        end else begin
            case (r_state)
                c_IDLE: if (bus.start) begin
                    r_op    <= bus.funct3;
                    r_rd    <= bus.rd_in;
                    r_neg_q <= w_sa ^ w_sb;
                    r_neg_r <= w_sa;
                    r_cnt   <= 6'd0;
                    if (bus.funct3[2]) begin
                        r_acc <= {32'd0, w_mag_a};
                        r_b   <= w_mag_b;
                    end else begin
                        r_acc <= {32'd0, w_mag_b};
                        r_b   <= w_mag_a;
                    end
                    if (w_fast) begin
                        r_result <= w_fast_res;
                        r_rd_out <= bus.rd_in;
                    end
                end
                c_CALC: begin
                    r_cnt <= r_cnt + 6'd1;
                    r_acc <= r_op[2] ? w_div_nxt : w_mul_nxt;
                end
                c_FIX: begin
                    r_result <= w_fix_res;
                    r_rd_out <= r_rd;
                end
                default: ;
            endcase
        end
    end

    assign bus.busy      = w_busy;
    assign bus.done      = w_done;
    assign bus.result    = r_result;
    assign bus.rd_out    = r_rd_out;
    assign bus.reg_write = w_reg_write;
endmodule
`default_nettype wire

// File: tb/tb_muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_muldiv_unit
// Description : Directed vector bench for muldiv_unit.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_muldiv_unit;
    logic clk;
    logic reset;
    muldiv_unit_if bus();

    muldiv_unit dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  f;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    localparam int NV = 22;
    vec_t vecs[NV];
    int n_chk;
    int n_fail;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd);
        @(negedge clk);
        bus.start    = 1'b1;
        bus.funct3   = f;
        bus.rs1_data = a;
        bus.rs2_data = b;
        bus.rd_in    = rd;
        @(posedge clk);
        #1;
        bus.start    = 1'b0;
        bus.funct3   = 3'($urandom);
        bus.rs1_data = $urandom;
        bus.rs2_data = $urandom;
        bus.rd_in    = 5'($urandom);
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int lat;
        bit got;
        lat = 0;
        got = 1'b0;
        issue(v.f, v.a, v.b, v.rd);
        while (lat < 60 && !got) begin
            @(negedge clk);
            lat++;
            if (lat == 1) chk($sformatf("v%0d busy_after_accept", idx), bus.busy, 1'b1);
            if (bus.done) got = 1'b1;
        end
        chk($sformatf("v%0d latency", idx), lat, v.lat);
        chk($sformatf("v%0d result", idx), bus.result, v.exp);
        chk($sformatf("v%0d rd_out", idx), bus.rd_out, v.rd);
        chk($sformatf("v%0d reg_write", idx), bus.reg_write, (v.rd != 5'd0));
        @(negedge clk);
        chk($sformatf("v%0d busy_after_done", idx), bus.busy, 1'b0);
        chk($sformatf("v%0d done_one_cycle", idx), bus.done, 1'b0);
        chk($sformatf("v%0d result_hold", idx), bus.result, v.exp);
    endtask

    initial begin
        int pulses;
        logic [31:0] seen_res;
        logic [4:0]  seen_rd;

        n_chk  = 0;
        n_fail = 0;
        vecs[0]  = '{3'b000, 32'd7,          32'hFFFF_FFFD, 5'd5,  32'hFFFF_FFEB, 34};
        vecs[1]  = '{3'b001, 32'h8000_0000,  32'h8000_0000, 5'd1,  32'h4000_0000, 34};
        vecs[2]  = '{3'b011, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd2,  32'hFFFF_FFFE, 34};
        vecs[3]  = '{3'b010, 32'hFFFF_FFFF,  32'd2,         5'd3,  32'hFFFF_FFFF, 34};
        vecs[4]  = '{3'b100, 32'hFFFF_FFF9,  32'd2,         5'd4,  32'hFFFF_FFFD, 34};
        vecs[5]  = '{3'b110, 32'hFFFF_FFF9,  32'd2,         5'd6,  32'hFFFF_FFFF, 34};
        vecs[6]  = '{3'b101, 32'hFFFF_FFF9,  32'd2,         5'd7,  32'h7FFF_FFFC, 34};
        vecs[7]  = '{3'b111, 32'hFFFF_FFF9,  32'd2,         5'd8,  32'd1,         34};
        vecs[8]  = '{3'b100, 32'd5,          32'd0,         5'd9,  32'hFFFF_FFFF, 1};
        vecs[9]  = '{3'b110, 32'd5,          32'd0,         5'd10, 32'd5,         1};
        vecs[10] = '{3'b100, 32'h8000_0000,  32'hFFFF_FFFF, 5'd11, 32'h8000_0000, 1};
        vecs[11] = '{3'b110, 32'h8000_0000,  32'hFFFF_FFFF, 5'd12, 32'd0,         1};
        vecs[12] = '{3'b101, 32'd5,          32'd0,         5'd13, 32'hFFFF_FFFF, 1};
        vecs[13] = '{3'b111, 32'd5,          32'd0,         5'd14, 32'd5,         1};
        vecs[14] = '{3'b000, 32'd3,          32'd4,         5'd0,  32'd12,        34};
        vecs[15] = '{3'b100, 32'd100,        32'd7,         5'd15, 32'd14,        34};
        vecs[16] = '{3'b110, 32'd100,        32'hFFFF_FFF9, 5'd16, 32'd2,         34};
        vecs[17] = '{3'b110, 32'hFFFF_FF9C,  32'd7,         5'd17, 32'hFFFF_FFFE, 34};
        vecs[18] = '{3'b001, 32'hFFFF_FFFF,  32'd3,         5'd18, 32'hFFFF_FFFF, 34};
        vecs[19] = '{3'b101, 32'hFFFF_FFFF,  32'd1,         5'd19, 32'hFFFF_FFFF, 34};
        vecs[20] = '{3'b100, 32'h8000_0000,  32'd1,         5'd20, 32'h8000_0000, 34};
        vecs[21] = '{3'b100, 32'h8000_0000,  32'd2,         5'd21, 32'hC000_0000, 34};

        reset        = 1'b0;
        bus.start    = 1'b0;
        bus.funct3   = 3'd0;
        bus.rs1_data = 32'd0;
        bus.rs2_data = 32'd0;
        bus.rd_in    = 5'd0;
        repeat (3) @(negedge clk);
        chk("reset busy",      bus.busy,      1'b0);
        chk("reset done",      bus.done,      1'b0);
        chk("reset reg_write", bus.reg_write, 1'b0);
        chk("reset result",    bus.result,    32'd0);
        chk("reset rd_out",    bus.rd_out,    5'd0);
        reset = 1'b1;

        for (int i = 0; i < NV; i++) run_vec(vecs[i], i);

        // Second start while busy must be dropped
        pulses   = 0;
        seen_res = 32'd0;
        seen_rd  = 5'd0;
        issue(3'b000, 32'd6, 32'd7, 5'd3);
        for (int n = 1; n <= 60; n++) begin
            @(negedge clk);
            if (bus.done) begin
                pulses++;
                seen_res = bus.result;
                seen_rd  = bus.rd_out;
            end
            if (n == 5) begin
                bus.start    = 1'b1;
                bus.funct3   = 3'b100;
                bus.rs1_data = 32'd9;
                bus.rs2_data = 32'd0;
                bus.rd_in    = 5'd9;
            end else begin
                bus.start = 1'b0;
            end
        end
        chk("busy_start done_pulses", pulses, 1);
        chk("busy_start result", seen_res, 32'd42);
        chk("busy_start rd_out", seen_rd, 5'd3);

        // Reset in the middle of a divide aborts it
        issue(3'b100, 32'd100, 32'd7, 5'd4);
        repeat (10) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("abort busy",      bus.busy,      1'b0);
        chk("abort done",      bus.done,      1'b0);
        chk("abort result",    bus.result,    32'd0);
        chk("abort rd_out",    bus.rd_out,    5'd0);
        chk("abort reg_write", bus.reg_write, 1'b0);
        reset  = 1'b1;
        pulses = 0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (bus.done) pulses++;
        end
        chk("abort no_done", pulses, 0);
        run_vec('{3'b000, 32'd1234, 32'd5678, 5'd22, 32'd7006652, 34}, 99);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
